// File: rtl/uart_defs.sv
// Shared UART definitions: FSM state encodings, default frame shape and line idle level.
// Used by both uart_tx and uart_rx so the two stay frame-compatible.
package uart_defs;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    localparam int   DEF_DATA_BITS = 8;
    localparam int   DEF_STOP_BITS = 2;
    localparam logic LINE_IDLE     = 1'b1;

endpackage

// File: rtl/uart_tx.sv
// Tick-paced UART transmitter with a single-entry holding register for gapless frames.
// Optional even parity bit between data and stop bits when UART_TX_PARITY_EN is defined.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_IDLE   | line high, waiting for a tick with the holding register full
// ST_START  | start bit (tx=0) on the line
// ST_DATA   | data bit bit_idx on the line, LSB first
// ST_PARITY | even parity bit on the line (UART_TX_PARITY_EN only)
// ST_STOP   | stop bit stop_cnt on the line (tx=1)
import uart_defs::*;

module uart_tx #(
    parameter int DATA_BITS = DEF_DATA_BITS,
    parameter int STOP_BITS = DEF_STOP_BITS
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 tick,
    input  logic                 tx_valid,
    input  logic [DATA_BITS-1:0] tx_data,
    output logic                 tx_ready,
    output logic                 tx,
    output logic                 tx_done,
    output logic                 busy
);

    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam int SW = $clog2(STOP_BITS + 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);
    localparam logic [SW-1:0] STOP_LAST = SW'(STOP_BITS - 1);

    uart_state_t          state;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] hold_data;
    logic                 hold_full;
    logic [BW-1:0]        bit_idx;
    logic [SW-1:0]        stop_cnt;
    logic [BW-1:0]        next_idx;
    logic                 stop_final;
    logic                 launch;

    assign next_idx   = bit_idx + 1'b1;
    assign stop_final = (state == ST_STOP) && (stop_cnt == STOP_LAST);
    assign launch     = tick && hold_full && ((state == ST_IDLE) || stop_final);

    assign tx_ready = ~hold_full;
    assign busy     = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            shift     <= '0;
            hold_data <= '0;
            hold_full <= 1'b0;
            bit_idx   <= '0;
            stop_cnt  <= '0;
            tx        <= LINE_IDLE;
            tx_done   <= 1'b0;
        end else begin
            tx_done <= tick && stop_final;

            // Accept needs an empty holding register, launch a full one, so they never collide.
            if (tx_valid && !hold_full) begin
                hold_data <= tx_data;
                hold_full <= 1'b1;
            end

            if (launch) begin
                shift     <= hold_data;
                hold_full <= 1'b0;
                tx        <= 1'b0;
                state     <= ST_START;
            end else if (tick) begin
                case (state)
                    ST_IDLE: begin
                        tx <= LINE_IDLE;
                    end
                    ST_START: begin
                        tx      <= shift[0];
                        bit_idx <= '0;
                        state   <= ST_DATA;
                    end
                    ST_DATA: begin
                        if (bit_idx == BIT_LAST) begin
                            stop_cnt <= '0;
`ifdef UART_TX_PARITY_EN
                            tx       <= ^shift;
                            state    <= ST_PARITY;
`else
                            tx       <= LINE_IDLE;
                            state    <= ST_STOP;
`endif
                        end else begin
                            bit_idx <= next_idx;
                            tx      <= shift[next_idx];
                        end
                    end
`ifdef UART_TX_PARITY_EN
                    ST_PARITY: begin
                        tx    <= LINE_IDLE;
                        state <= ST_STOP;
                    end
`endif
                    ST_STOP: begin
                        if (stop_cnt == STOP_LAST) begin
                            tx    <= LINE_IDLE;
                            state <= ST_IDLE;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                    default: begin
                        tx    <= LINE_IDLE;
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx.sv
// Scoreboard bench for uart_tx: stimulus pushes expected bytes, a line monitor decodes frames.
module tb_uart_tx;

`ifdef UART_TX_PARITY_EN
    localparam int FRAME = 12;
`else
    localparam int FRAME = 11;
`endif

    logic       clk = 1'b0;
    logic       rst;
    logic       tick;
    logic       tx_valid;
    logic [7:0] tx_data;
    logic       tx_ready;
    logic       tx;
    logic       tx_done;
    logic       busy;

    int total = 0;
    int bad   = 0;

    logic [8:0] exp_q[$];
    int pushes   = 0;
    int done_cnt = 0;
    int cyc      = 0;
    int done_t_prev = 0;
    int done_t_last = 0;

    int tick_period = 16;
    logic tick_en = 1'b1;

    int mon_st = 0;
    int mon_n  = 0;
    logic [7:0] mon_data;
    logic mon_par;
    logic pend_done = 1'b0;

    uart_tx dut (
        .clk      (clk),
        .rst      (rst),
        .tick     (tick),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .tx_ready (tx_ready),
        .tx       (tx),
        .tx_done  (tx_done),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // tick generator, driven just after the rising edge
    initial begin
        int tcnt;
        tcnt = 0;
        tick = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_en) begin
                if (tcnt >= tick_period - 1) begin
                    tick = 1'b1;
                    tcnt = 0;
                end else begin
                    tick = 1'b0;
                    tcnt++;
                end
            end else begin
                tick = 1'b0;
                tcnt = 0;
            end
        end
    end

    // line monitor: samples tx at each tick edge (value of the bit being ended)
    initial begin
        logic [8:0] e;
        forever begin
            @(negedge clk);
            if (rst) begin
                mon_st = 0;
                mon_n = 0;
                pend_done = 1'b0;
            end else begin
                if (pend_done) begin
                    chk("tx_done_pulse", tx_done, 1'b1);
                    pend_done = 1'b0;
                end else if (tx_done) begin
                    chk("tx_done_spurious", tx_done, 1'b0);
                end
                if (tx_done) begin
                    done_cnt++;
                    done_t_prev = done_t_last;
                    done_t_last = cyc;
                end
                if (tick) begin
                    case (mon_st)
                        0: if (tx == 1'b0) begin
                            mon_st = 1;
                            mon_n = 0;
                        end
                        1: begin
                            mon_data[mon_n] = tx;
                            mon_n++;
                            if (mon_n == 8) begin
`ifdef UART_TX_PARITY_EN
                                mon_st = 2;
`else
                                mon_st = 3;
`endif
                                mon_n = 0;
                            end
                        end
                        2: begin
                            mon_par = tx;
                            mon_st = 3;
                        end
                        default: begin
                            chk("stop_bit", tx, 1'b1);
                            mon_n++;
                            if (mon_n == 2) begin
                                mon_st = 0;
                                pend_done = 1'b1;
                                if (exp_q.size() == 0) begin
                                    chk("unexpected_frame", {24'd0, mon_data}, 32'hFFFF_FFFF);
                                end else begin
                                    e = exp_q.pop_front();
                                    chk("frame_data", mon_data, e[7:0]);
`ifdef UART_TX_PARITY_EN
                                    chk("parity_bit", mon_par, e[8]);
`endif
                                end
                            end
                        end
                    endcase
                end
            end
        end
    end

    task automatic send(input logic [7:0] b, input logic push, input logic par);
        int i;
        @(negedge clk);
        tx_valid = 1'b1;
        tx_data = b;
        i = 0;
        while (!tx_ready && i < 5000) begin
            @(negedge clk);
            i++;
        end
        if (!tx_ready) begin
            chk("send_timeout", tx_ready, 1'b1);
        end else if (push) begin
            exp_q.push_back({par, b});
            pushes++;
        end
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic wait_tick();
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tick) begin
                @(negedge clk);
                return;
            end
        end
        chk("tick_timeout", 0, 1);
    endtask

    task automatic wait_idle();
        int good;
        good = 0;
        for (int i = 0; i < 60000; i++) begin
            @(negedge clk);
            if (!busy && tx_ready && exp_q.size() == 0 && mon_st == 0 && !pend_done) good++;
            else good = 0;
            if (good >= 2) return;
        end
        chk("idle_timeout", 0, 1);
    endtask

    initial begin
        logic ok_tx, ok_busy;
        int d0;
        rst = 1'b1;
        tx_valid = 1'b0;
        tx_data = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_tx", tx, 1'b1);
        chk("reset_tx_ready", tx_ready, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_tx_done", tx_done, 1'b0);

        // single frame, launch timing
        send(8'hA5, 1'b1, 1'b0);
        chk("accept_ready_low", tx_ready, 1'b0);
        wait_tick();
        chk("launch_tx_low", tx, 1'b0);
        chk("launch_ready_high", tx_ready, 1'b1);
        chk("launch_busy", busy, 1'b1);
        wait_idle();

        // back-to-back frames
        send(8'h00, 1'b1, 1'b0);
        send(8'hFF, 1'b1, 1'b0);
        wait_idle();
        chk("b2b_done_spacing", done_t_last - done_t_prev, FRAME * 16);

        // reset after data bit 3
        d0 = done_cnt;
        send(8'h3C, 1'b0, 1'b0);
        repeat (6) wait_tick();
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx", tx, 1'b1);
        chk("abort_busy", busy, 1'b0);
        chk("abort_ready", tx_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_no_done", done_cnt, d0);
        send(8'h3C, 1'b1, 1'b0);
        wait_idle();

        // tick held low
        tick_en = 1'b0;
        repeat (4) @(negedge clk);
        send(8'h55, 1'b1, 1'b0);
        chk("frozen_ready", tx_ready, 1'b0);
        ok_tx = 1'b1;
        ok_busy = 1'b1;
        repeat (50) begin
            @(negedge clk);
            if (tx !== 1'b1) ok_tx = 1'b0;
            if (busy !== 1'b0) ok_busy = 1'b0;
        end
        chk("frozen_tx_high", ok_tx, 1'b1);
        chk("frozen_not_busy", ok_busy, 1'b0 ^ 1'b1);
        tick_en = 1'b1;
        wait_tick();
        chk("first_tick_start", tx, 1'b0);
        wait_idle();

`ifdef UART_TX_PARITY_EN
        send(8'h07, 1'b1, 1'b1);
        send(8'h03, 1'b1, 1'b0);
        wait_idle();
        chk("parity_done_spacing", done_t_last - done_t_prev, FRAME * 16);
`endif

        // every byte value, back-to-back at a faster tick
        tick_period = 4;
        for (int b = 0; b < 256; b++) begin
            send(8'(b), 1'b1, ^(8'(b)));
        end
        wait_idle();
        chk("done_count", done_cnt, pushes);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

endmodule
